// File: rtl/rng_gen.sv
// rng_gen: seedable Fibonacci-style LFSR random source with warm-up,
// free-running or read-driven stepping, and an accepted-read counter.
module rng_gen #(
  parameter int unsigned      WIDTH      = 64,
  parameter int unsigned      SEED_W     = 32,
  parameter logic [WIDTH-1:0] POLY       = WIDTH'(64'hD800_0000_0000_0000),
  parameter int unsigned      WARMUP     = 64,
  parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              seed_wr,
  input  logic [SEED_W-1:0] seed,
  input  logic              kick,
  input  logic              free_run,
  input  logic              out_rd,
  output logic [WIDTH-1:0]  out,
  output logic              out_valid,
  output logic              busy,
  output logic [31:0]       draw_cnt
);

  localparam int unsigned CW   = $clog2(WARMUP + 1);
  localparam int unsigned REPS = (WIDTH + SEED_W - 1) / SEED_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WARM  = 2'd1,
    READY = 2'd2
  } fsm_t;

  fsm_t          fsm;
  logic [CW-1:0] cnt;

  // One LFSR step: shift left, feedback is parity of the tapped bits
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & POLY)};
  endfunction

  // Seed replicated upward from bit 0, truncated; an all-zero result locks the LFSR so use 1
  function automatic logic [WIDTH-1:0] seed_value(input logic [SEED_W-1:0] s);
    logic [WIDTH-1:0] v;
    v = WIDTH'({REPS{s}});
    if (v == '0) v = WIDTH'(1);
    return v;
  endfunction

  // Control FSM, LFSR state (driven straight onto out), warm-up and draw counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out       <= RESET_SEED;
      fsm       <= IDLE;
      cnt       <= '0;
      draw_cnt  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (seed_wr) begin
      out       <= seed_value(seed);
      fsm       <= WARM;
      cnt       <= '0;
      draw_cnt  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b1;
    end else if (kick) begin
      // IDLE holds the LFSR still, so a kick from IDLE does not step it
      if (fsm != IDLE) out <= lfsr_step(out);
      fsm       <= WARM;
      cnt       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b1;
    end else begin
      case (fsm)
        IDLE: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
        WARM: begin
          out <= lfsr_step(out);
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WARMUP - 1)) begin
            fsm       <= READY;
            out_valid <= 1'b1;
            busy      <= 1'b0;
          end
        end
        READY: begin
          if (free_run || out_rd) out <= lfsr_step(out);
          if (out_rd && (draw_cnt != 32'hFFFF_FFFF)) draw_cnt <= draw_cnt + 32'd1;
        end
        default: begin
          fsm       <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rng_gen.sv
// tb_rng_gen: directed + lightly randomised bench for rng_gen (WIDTH=64, WARMUP=4)
// with a cycle model compared against the DUT on every falling edge.
module tb_rng_gen;

  localparam int unsigned WIDTH  = 64;
  localparam int unsigned SEED_W = 32;
  localparam int unsigned WARMUP = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              seed_wr = 1'b0;
  logic [SEED_W-1:0] seed = '0;
  logic              kick = 1'b0;
  logic              free_run = 1'b0;
  logic              out_rd = 1'b0;
  logic [WIDTH-1:0]  out;
  logic              out_valid;
  logic              busy;
  logic [31:0]       draw_cnt;

  int vectors = 0;
  int miscompares = 0;

  rng_gen #(
    .WIDTH (WIDTH),
    .SEED_W(SEED_W),
    .WARMUP(WARMUP)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .seed_wr  (seed_wr),
    .seed     (seed),
    .kick     (kick),
    .free_run (free_run),
    .out_rd   (out_rd),
    .out      (out),
    .out_valid(out_valid),
    .busy     (busy),
    .draw_cnt (draw_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: "warm_left" counts remaining warm-up steps; idle means neither warming nor valid
  logic [63:0] m_out   = 64'h1;
  bit          m_valid = 1'b0;
  int          m_warm  = 0;
  longint      m_draw  = 0;

  function automatic logic [63:0] m_next(input logic [63:0] s);
    logic fb;
    fb = s[63] ^ s[62] ^ s[60] ^ s[59];   // taps of 0xD800_0000_0000_0000
    return {s[62:0], fb};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_out = 64'h1; m_valid = 1'b0; m_warm = 0; m_draw = 0;
    end else if (seed_wr) begin
      m_out = {seed, seed};
      if (m_out == 64'h0) m_out = 64'h1;
      m_warm = WARMUP; m_valid = 1'b0; m_draw = 0;
    end else if (kick) begin
      if (m_valid || m_warm > 0) m_out = m_next(m_out);
      m_warm = WARMUP; m_valid = 1'b0;
    end else if (m_warm > 0) begin
      m_out  = m_next(m_out);
      m_warm = m_warm - 1;
      if (m_warm == 0) m_valid = 1'b1;
    end else if (m_valid) begin
      if (free_run || out_rd) m_out = m_next(m_out);
      if (out_rd && m_draw < 64'hFFFF_FFFF) m_draw = m_draw + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%016h expected 0x%016h", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("out", out, m_out);
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("busy", 64'(busy), 64'(m_warm > 0));
    chk("draw_cnt", 64'(draw_cnt), 64'(m_draw));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_rd();
    out_rd = 1'b1; cyc(1); out_rd = 1'b0;
  endtask

  initial begin
    // Reset held, then idle
    cyc(3);
    chk("rst_out", out, 64'h1);
    chk("rst_valid", 64'(out_valid), 64'h0);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("idle_out", out, 64'h1);
      chk("idle_busy", 64'(busy), 64'h0);
      chk("idle_valid", 64'(out_valid), 64'h0);
    end

    // Seed 1 and warm up
    seed = 32'h1; seed_wr = 1'b1; cyc(1); seed_wr = 1'b0;
    chk("seed1_out", out, 64'h0000_0001_0000_0001);
    chk("seed1_busy", 64'(busy), 64'h1);
    cyc(3);
    chk("warm_not_valid", 64'(out_valid), 64'h0);
    cyc(1);
    chk("warm_done_out", out, 64'h0000_0010_0000_0010);
    chk("warm_done_valid", 64'(out_valid), 64'h1);

    // Read-driven stepping
    pulse_rd();
    chk("rd1_out", out, 64'h0000_0020_0000_0020);
    chk("rd1_draw", 64'(draw_cnt), 64'h1);
    cyc(3);
    chk("rd_hold_out", out, 64'h0000_0020_0000_0020);
    for (int i = 0; i < 4; i++) begin pulse_rd(); cyc(1); end
    chk("rd5_draw", 64'(draw_cnt), 64'h5);

    // Free-running for a few cycles, no reads
    free_run = 1'b1; cyc(5); free_run = 1'b0; cyc(1);

    // Kick in READY: valid drops for WARMUP cycles, draw count kept
    kick = 1'b1; cyc(1); kick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("kick_valid_low", 64'(out_valid), 64'h0);
      cyc(1);
    end
    chk("kick_valid_low", 64'(out_valid), 64'h0);
    cyc(1);
    chk("kick_valid_high", 64'(out_valid), 64'h1);
    chk("kick_draw_kept", 64'(draw_cnt), 64'h5);

    // Zero seed substitutes 1
    seed = 32'h0; seed_wr = 1'b1; cyc(1); seed_wr = 1'b0;
    chk("seed0_out", out, 64'h1);
    chk("seed0_draw", 64'(draw_cnt), 64'h0);
    cyc(4);
    chk("seed0_warm_out", out, 64'h10);
    pulse_rd(); pulse_rd();

    // seed_wr + kick + out_rd together: seed wins, read not counted
    seed = 32'hDEAD_BEEF; seed_wr = 1'b1; kick = 1'b1; out_rd = 1'b1;
    cyc(1);
    seed_wr = 1'b0; kick = 1'b0; out_rd = 1'b0;
    chk("prec_out", out, 64'hDEAD_BEEF_DEAD_BEEF);
    chk("prec_draw", 64'(draw_cnt), 64'h0);

    // Async reset mid-WARM
    cyc(1);
    @(posedge clk); #1 reset_n = 1'b0;
    #1;
    chk("async_out", out, 64'h1);
    chk("async_busy", 64'(busy), 64'h0);
    chk("async_valid", 64'(out_valid), 64'h0);
    cyc(2); reset_n = 1'b1; cyc(3);
    chk("post_rst_idle_out", out, 64'h1);

    // Kick from IDLE: no step on the kick edge
    kick = 1'b1; cyc(1); kick = 1'b0;
    chk("kick_idle_out", out, 64'h1);
    chk("kick_idle_busy", 64'(busy), 64'h1);
    cyc(4);
    chk("kick_idle_done", out, 64'h10);

    // Mixed traffic
    for (int i = 0; i < 120; i++) begin
      free_run = 1'($urandom_range(0, 1));
      out_rd   = 1'($urandom_range(0, 2) == 0);
      kick     = 1'($urandom_range(0, 29) == 0);
      seed_wr  = 1'($urandom_range(0, 39) == 0);
      seed     = $urandom;
      cyc(1);
    end
    seed_wr = 1'b0; kick = 1'b0; out_rd = 1'b0; free_run = 1'b0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
